dma_buf_ram: RTL and testbench

DMA_BUF_RAM -- requirements
Module: dma_buf_ram

---
 rtl/dma_buf_ram_if.sv | 37 +++
 rtl/dma_buf_ram.sv | 91 +++++++++
 tb/tb_dma_buf_ram.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_buf_ram_if.sv
// Burst-engine side bundle of the DMA staging buffer.
interface dma_buf_ram_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_en;
  logic                  rd_dat_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  clr;
  logic [ADDR_WIDTH:0]   xfer_len;
  logic [ADDR_WIDTH:0]   wr_cnt;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic                  wr_done;
  logic                  rd_done;
  logic                  full;
  logic                  collision;

  modport master (
    output wr_addr, wr_en, wr_data,
    output rd_addr, rd_en, clr, xfer_len,
    input  rd_dat_vld, rd_data,
    input  wr_cnt, rd_cnt, wr_done, rd_done,
    input  full, collision
  );

  modport slave (
    input  wr_addr, wr_en, wr_data,
    input  rd_addr, rd_en, clr, xfer_len,
    output rd_dat_vld, rd_data,
    output wr_cnt, rd_cnt, wr_done, rd_done,
    output full, collision
  );
endinterface

// File: rtl/dma_buf_ram.sv
// DMA staging buffer: single-clock RAM, 2-stage read pipeline,
// transfer counters with done pulses, and a collision flag.
module dma_buf_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic         M_AXI_ACLK,
  input  logic         M_AXI_ARESETN,
  dma_buf_ram_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_MAX =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LP_ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_s1_vld;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic                  r_rd_vld;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [ADDR_WIDTH:0]   r_wr_cnt;
  logic [ADDR_WIDTH:0]   r_rd_cnt;
  logic                  r_wr_done;
  logic                  r_rd_done;
  logic                  r_coll;
  logic                  w_wr_inc;
  logic                  w_rd_inc;
  logic                  w_rd_load;
  logic [ADDR_WIDTH:0]   w_wr_nxt;
  logic [ADDR_WIDTH:0]   w_rd_nxt;

  // Array has no reset; a write at E0 lands before the E1 read.
  always_ff @(posedge M_AXI_ACLK) begin
    if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;
  end

  always_comb begin
    w_wr_inc  = bus.wr_en && (r_wr_cnt != LP_MAX);
    w_rd_inc  = r_rd_vld && (r_rd_cnt != LP_MAX);
    w_rd_load = r_s1_vld && !bus.clr;
    w_wr_nxt  = r_wr_cnt + LP_ONE;
    w_rd_nxt  = r_rd_cnt + LP_ONE;
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_s1_vld  <= 1'b0;
      r_s1_addr <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
      r_coll    <= 1'b0;
    end else begin
      r_s1_vld <= bus.rd_en && !bus.clr;
      if (bus.rd_en) r_s1_addr <= bus.rd_addr;
      r_rd_vld <= w_rd_load;
      if (w_rd_load) r_rd_data <= r_mem[r_s1_addr];
      r_coll <= bus.wr_en && bus.rd_en &&
                (bus.wr_addr == bus.rd_addr);
    end
  end

  // Done fires only on the step that lands on xfer_len.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
    end else if (bus.clr) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
    end else begin
      if (w_wr_inc) r_wr_cnt <= w_wr_nxt;
      if (w_rd_inc) r_rd_cnt <= w_rd_nxt;
      r_wr_done <= w_wr_inc && (w_wr_nxt == bus.xfer_len);
      r_rd_done <= w_rd_inc && (w_rd_nxt == bus.xfer_len);
    end
  end

  assign bus.rd_dat_vld = r_rd_vld;
  assign bus.rd_data    = r_rd_data;
  assign bus.wr_cnt     = r_wr_cnt;
  assign bus.rd_cnt     = r_rd_cnt;
  assign bus.wr_done    = r_wr_done;
  assign bus.rd_done    = r_rd_done;
  assign bus.full       = (r_wr_cnt == LP_MAX);
  assign bus.collision  = r_coll;
endmodule

// File: tb/tb_dma_buf_ram.sv
// Scoreboard bench for dma_buf_ram: directed scenarios plus random
// traffic against an array/queue reference model.
module tb_dma_buf_ram;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dma_buf_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dma_buf_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .bus          (bus)
  );

  typedef struct {
    int            e;
    logic [DW-1:0] d;
  } rd_t;

  typedef struct {
    int e;
    int wr;
    int rd;
  } snap_t;

  rd_t           rd_q[$];
  snap_t         snap_q[$];
  int            wd_q[$];
  int            rdn_q[$];
  int            col_q[$];
  int            pend_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] last_d;
  int            wr_m, rd_m, xl, cyc;
  int            n_chk, n_pass;
  bit            ev_rd, ev_wd, ev_rdn, ev_col;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endfunction

  // Monitor: pops expectations whose time has come.
  always @(negedge clk) begin
    if (rst_n) begin
      ev_rd = (rd_q.size() > 0) && (rd_q[0].e + 1 == cyc);
      if (ev_rd || bus.rd_dat_vld)
        chk("rd_dat_vld", 64'(bus.rd_dat_vld), 64'(ev_rd));
      if (ev_rd) begin
        chk("rd_data", 64'(bus.rd_data), 64'(rd_q[0].d));
        last_d = rd_q[0].d;
        void'(rd_q.pop_front());
      end else begin
        chk("rd_data_hold", 64'(bus.rd_data), 64'(last_d));
      end
      ev_wd = (wd_q.size() > 0) && (wd_q[0] == cyc);
      if (ev_wd || bus.wr_done)
        chk("wr_done", 64'(bus.wr_done), 64'(ev_wd));
      if (ev_wd) void'(wd_q.pop_front());
      ev_rdn = (rdn_q.size() > 0) && (rdn_q[0] == cyc);
      if (ev_rdn || bus.rd_done)
        chk("rd_done", 64'(bus.rd_done), 64'(ev_rdn));
      if (ev_rdn) void'(rdn_q.pop_front());
      ev_col = (col_q.size() > 0) && (col_q[0] == cyc);
      if (ev_col || bus.collision)
        chk("collision", 64'(bus.collision), 64'(ev_col));
      if (ev_col) void'(col_q.pop_front());
      if (snap_q.size() > 0 && snap_q[0].e == cyc) begin
        chk("wr_cnt", 64'(bus.wr_cnt), 64'(snap_q[0].wr));
        chk("rd_cnt", 64'(bus.rd_cnt), 64'(snap_q[0].rd));
        chk("full", 64'(bus.full), 64'(snap_q[0].wr == DEPTH));
        void'(snap_q.pop_front());
      end
    end
  end

  task automatic drive_idle();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    bus.clr      = 1'b0;
    bus.xfer_len = (AW+1)'(xl);
  endtask

  // One clock of stimulus; the model reasons in whole edges.
  task automatic step(input bit we, input int wa,
                      input logic [DW-1:0] wd, input bit re,
                      input int ra, input bit c);
    int    e;
    rd_t   r;
    snap_t s;
    e = cyc + 1;
    bus.wr_en    = we;
    bus.wr_addr  = AW'(wa);
    bus.wr_data  = wd;
    bus.rd_en    = re;
    bus.rd_addr  = AW'(ra);
    bus.clr      = c;
    bus.xfer_len = (AW+1)'(xl);
    if (we) mem_m[AW'(wa)] = wd;
    if (we && re && wa == ra) col_q.push_back(e);
    if (c) begin
      wr_m = 0;
      rd_m = 0;
      pend_q.delete();
      while (rd_q.size() > 0 && rd_q[$].e >= e - 1)
        void'(rd_q.pop_back());
    end else begin
      if (we && wr_m < DEPTH) begin
        wr_m++;
        if (wr_m == xl) wd_q.push_back(e);
      end
      if (pend_q.size() > 0 && pend_q[0] == e - 2) begin
        void'(pend_q.pop_front());
        if (rd_m < DEPTH) begin
          rd_m++;
          if (rd_m == xl) rdn_q.push_back(e);
        end
      end
      if (re) begin
        pend_q.push_back(e);
        r.e = e;
        r.d = mem_m[AW'(ra)];
        rd_q.push_back(r);
      end
    end
    s.e  = e;
    s.wr = wr_m;
    s.rd = rd_m;
    snap_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_rd_dat_vld", 64'(bus.rd_dat_vld), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_wr_cnt", 64'(bus.wr_cnt), 64'd0);
    chk("rst_rd_cnt", 64'(bus.rd_cnt), 64'd0);
    chk("rst_wr_done", 64'(bus.wr_done), 64'd0);
    chk("rst_rd_done", 64'(bus.rd_done), 64'd0);
    chk("rst_collision", 64'(bus.collision), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    rd_q.delete();
    snap_q.delete();
    wd_q.delete();
    rdn_q.delete();
    col_q.delete();
    pend_q.delete();
    wr_m   = 0;
    rd_m   = 0;
    last_d = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit c;
    xl = 0;
    drive_idle();
    #1;
    do_reset();

    for (int i = 0; i < 16; i++)
      step(1, i, 32'hA5A5_0000 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, '0, 1, i, 0);
    idle(3);

    step(0, 0, '0, 0, 0, 1);
    step(1, 5, 32'h1234, 1, 5, 0);
    step(1, 5, 32'h5678, 0, 0, 0);
    idle(3);

    xl = 8;
    step(0, 0, '0, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      step(1, int'($urandom_range(0, 15)), $urandom, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 4; i++)
      step(1, int'($urandom_range(0, 15)), $urandom, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step(0, 0, '0, 1, int'($urandom_range(0, 15)), 0);
    idle(4);

    xl = 0;
    step(0, 0, '0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, i % 16, $urandom, 0, 0, 0);
    step(0, 0, '0, 1, 3, 0);
    idle(3);

    xl = 8;
    step(0, 0, '0, 0, 0, 1);
    step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 1, 1, 1);
    step(0, 0, '0, 1, 2, 0);
    step(0, 0, '0, 1, 3, 0);
    idle(4);

    step(0, 0, '0, 1, 2, 0);
    do_reset();
    step(0, 0, '0, 1, 3, 0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 19) == 0);
      if (c) xl = int'($urandom_range(0, 18));
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           $urandom, bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), c);
    end
    idle(4);

    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("wr_done_q_drained", 64'(wd_q.size()), 64'd0);
    chk("rd_done_q_drained", 64'(rdn_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
